// File: rtl/avl_sdram_pkg.sv
// Shared types and default sizing for the Avalon SDRAM command master.
package avl_sdram_pkg;

  localparam int AVL_ADDR_W      = 25;
  localparam int AVL_DATA_W      = 16;
  localparam int AVL_TIMEOUT_DEF = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } avl_state_t;

  typedef struct packed {
    logic                  write;
    logic                  err;
    logic [AVL_DATA_W-1:0] rdata;
  } avl_rsp_t;

endpackage

// File: rtl/avl_sdram_master.sv
// Single-outstanding Avalon-MM master: one command in, one bus transaction,
// one response out. Bus waits are bounded by TIMEOUT cycles, after which
// the transaction is abandoned and an error response is returned.
module avl_sdram_master
  import avl_sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = AVL_ADDR_W,
  parameter int DATA_WIDTH = AVL_DATA_W,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT    = AVL_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [BE_WIDTH-1:0]   cmd_be,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // Avalon master
  output logic [ADDR_WIDTH-1:0] address,
  output logic [BE_WIDTH-1:0]   byteenable_n,
  output logic                  chipselect,
  output logic                  read_n,
  output logic                  write_n,
  output logic [DATA_WIDTH-1:0] writedata,
  input  logic [DATA_WIDTH-1:0] readdata,
  input  logic                  readdatavalid,
  input  logic                  waitrequest
);

  localparam int CW = $clog2(TIMEOUT + 1);

  avl_state_t            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] writedata_q, writedata_d;
  logic [BE_WIDTH-1:0]   be_n_q, be_n_d;
  logic                  cs_q, cs_d;
  logic                  read_n_q, read_n_d;
  logic                  write_n_q, write_n_d;
  logic                  expired;

  // Next-state and next-output logic; every bus/response output is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    be_n_d      = be_n_q;
    cs_d        = cs_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    expired     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          address_d   = cmd_addr;
          writedata_d = cmd_wdata;
          be_n_d      = ~cmd_be;
          cs_d        = 1'b1;
          cnt_d       = '0;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            write_n_d = 1'b0;
            state_d   = WR_REQ;
          end else begin
            read_n_d = 1'b0;
            state_d  = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (!waitrequest) begin
          write_n_d   = 1'b1;
          cs_d        = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          expired = 1'b1;
        end
      end

      RD_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (!waitrequest && readdatavalid) begin
          // data returned on the same edge the request was taken
          read_n_d    = 1'b1;
          cs_d        = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = readdata;
          state_d     = RESP;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          expired = 1'b1;
        end else if (!waitrequest) begin
          read_n_d = 1'b1;
          state_d  = RD_WAIT;
        end
      end

      RD_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (readdatavalid) begin
          cs_d        = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = readdata;
          state_d     = RESP;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          expired = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Abandon the bus: strobes idle, error response with no data.
    if (expired) begin
      read_n_d    = 1'b1;
      write_n_d   = 1'b1;
      cs_d        = 1'b0;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      state_d     = RESP;
    end

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      be_n_q      <= '1;
      cs_q        <= 1'b0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      be_n_q      <= be_n_d;
      cs_q        <= cs_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign address      = address_q;
  assign writedata    = writedata_q;
  assign byteenable_n = be_n_q;
  assign chipselect   = cs_q;
  assign read_n       = read_n_q;
  assign write_n      = write_n_q;

endmodule
